bus_sequencer: RTL

BUS_SEQUENCER -- requirements
Module: bus_sequencer

---
 rtl/bus_sequencer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/bus_sequencer.sv
// bus_sequencer: multiplexed 8-bit external bus sequencer for a 16-bit CPU core.
// One access runs ADDR_LO -> ADDR_HI -> DATA -> DONE. The next state and the
// outputs are computed together and registered on the same edge, so every
// output is already valid in the cycle it belongs to.
// Optional feature: define BUS_WAIT_EN to let EXT_WAIT stretch the DATA phase,
// with a WAIT_MAX timeout that returns 8'hFF and sets a sticky BUS_ERR.
module bus_sequencer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] CPU_ADDRESS,
  input  logic        CPU_RW,
  input  logic [7:0]  CPU_DATA_OUT,
  input  logic        CPU_REQ,
  output logic [7:0]  CPU_DATA_IN,
  output logic        CPU_RDY,
  output logic [7:0]  IO_OUT,
  input  logic [7:0]  IO_IN,
  output logic [7:0]  IO_OE,
  output logic [1:0]  PHASE,
  output logic        EXT_RW,
  input  logic        EXT_WAIT,
  output logic        BUS_ERR
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  localparam logic [1:0] PH_IDLE = 2'b00;
  localparam logic [1:0] PH_LO   = 2'b01;
  localparam logic [1:0] PH_HI   = 2'b10;
  localparam logic [1:0] PH_DATA = 2'b11;

  localparam logic [DATA_W-1:0] OE_DRIVE = 8'hFF;
  localparam logic [DATA_W-1:0] OE_INPUT = 8'h00;

  // Reject out-of-range wait limits at elaboration time.
  if (WAIT_MAX == 0 || WAIT_MAX > 255) begin : g_bad_wait_max
    $error("bus_sequencer: WAIT_MAX must be in 1..255");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_LO,
    S_ADDR_HI,
    S_DATA,
    S_DONE
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   addr_q, addr_n;
  logic                rw_q, rw_n;
  logic [DATA_W-1:0]   wdata_q, wdata_n;
  logic [DATA_W-1:0]   data_in_n;
  logic                rdy_n;
  logic [DATA_W-1:0]   io_out_n;
  logic [DATA_W-1:0]   io_oe_n;
  logic [1:0]          phase_n;
  logic                ext_rw_n;
  logic                leave_data;
  logic                timeout;

`ifdef BUS_WAIT_EN
  localparam int unsigned     CNT_W      = 8;
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(WAIT_MAX);

  logic [CNT_W-1:0] wait_cnt, wait_cnt_n;
  logic             bus_err_n;
`else
  logic unused_ext_wait;
  assign unused_ext_wait = EXT_WAIT;
  assign BUS_ERR         = 1'b0;
`endif

  // Next state, latched access and next-cycle output decode.
  always_comb begin
    state_n    = state;
    addr_n     = addr_q;
    rw_n       = rw_q;
    wdata_n    = wdata_q;
    data_in_n  = CPU_DATA_IN;
    leave_data = 1'b1;
    timeout    = 1'b0;
`ifdef BUS_WAIT_EN
    wait_cnt_n = wait_cnt;
    bus_err_n  = BUS_ERR;
`endif

    case (state)
      S_IDLE, S_DONE: begin
        if (CPU_REQ) begin
          state_n = S_ADDR_LO;
          addr_n  = CPU_ADDRESS;
          rw_n    = CPU_RW;
          wdata_n = CPU_DATA_OUT;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_ADDR_LO: state_n = S_ADDR_HI;
      S_ADDR_HI: state_n = S_DATA;
      S_DATA: begin
`ifdef BUS_WAIT_EN
        if (EXT_WAIT) begin
          if (wait_cnt < WAIT_LIMIT) begin
            leave_data = 1'b0;
            wait_cnt_n = wait_cnt + CNT_W'(1);
          end else begin
            timeout = 1'b1;
          end
        end
`endif
        if (leave_data) begin
          state_n = S_DONE;
          if (rw_q) begin
            data_in_n = timeout ? 8'hFF : IO_IN;
          end
`ifdef BUS_WAIT_EN
          wait_cnt_n = '0;
          if (timeout) begin
            bus_err_n = 1'b1;
          end
`endif
        end
      end
      default: state_n = S_IDLE;
    endcase

    rdy_n    = 1'b0;
    io_out_n = 8'h00;
    io_oe_n  = OE_INPUT;
    phase_n  = PH_IDLE;
    ext_rw_n = 1'b1;

    case (state_n)
      S_ADDR_LO: begin
        io_out_n = addr_n[7:0];
        io_oe_n  = OE_DRIVE;
        phase_n  = PH_LO;
        ext_rw_n = rw_n;
      end
      S_ADDR_HI: begin
        io_out_n = addr_n[15:8];
        io_oe_n  = OE_DRIVE;
        phase_n  = PH_HI;
        ext_rw_n = rw_n;
      end
      S_DATA: begin
        phase_n  = PH_DATA;
        ext_rw_n = rw_n;
        if (!rw_n) begin
          io_out_n = wdata_n;
          io_oe_n  = OE_DRIVE;
        end
      end
      S_DONE: begin
        rdy_n    = 1'b1;
        ext_rw_n = rw_n;
      end
      default: ;
    endcase
  end

  // State, latched access and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      rw_q        <= 1'b1;
      wdata_q     <= '0;
      CPU_DATA_IN <= 8'h00;
      CPU_RDY     <= 1'b0;
      IO_OUT      <= 8'h00;
      IO_OE       <= OE_INPUT;
      PHASE       <= PH_IDLE;
      EXT_RW      <= 1'b1;
    end else begin
      state       <= state_n;
      addr_q      <= addr_n;
      rw_q        <= rw_n;
      wdata_q     <= wdata_n;
      CPU_DATA_IN <= data_in_n;
      CPU_RDY     <= rdy_n;
      IO_OUT      <= io_out_n;
      IO_OE       <= io_oe_n;
      PHASE       <= phase_n;
      EXT_RW      <= ext_rw_n;
    end
  end

`ifdef BUS_WAIT_EN
  // Wait counter and sticky timeout flag.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wait_cnt <= '0;
      BUS_ERR  <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_n;
      BUS_ERR  <= bus_err_n;
    end
  end
`endif

endmodule
